// File: rtl/cmd_queue_frontend_if.sv
// -----------------------------------------------------------------------------
// cmd_queue_frontend_if
// Bundles the two handshakes of the command front-end:
//   submission side : i_push / i_cmd (per channel) with o_grant as the accept
//   issuer side     : o_cmd (FIFO head), o_empty, i_rd (pop)
// Signal names are written from the front-end's point of view.
// Modports:
//   master - host/issuer side (drives requests, pops and commands)
//   slave  - the front-end itself
// -----------------------------------------------------------------------------
interface cmd_queue_frontend_if #(
  parameter int CMD_W    = 64,
  parameter int CH_COUNT = 2
);

  logic [CH_COUNT-1:0] i_push;
  logic [CMD_W-1:0]    i_cmd [CH_COUNT-1:0];
  logic [CH_COUNT-1:0] o_grant;
  logic [CMD_W-1:0]    o_cmd;
  logic                o_empty;
  logic                i_rd;

  modport master (
    output i_push, i_cmd, i_rd,
    input  o_grant, o_cmd, o_empty
  );

  modport slave (
    input  i_push, i_cmd, i_rd,
    output o_grant, o_cmd, o_empty
  );

endinterface

// File: rtl/cmd_queue_frontend.sv
// -----------------------------------------------------------------------------
// cmd_queue_frontend
// Merges CH_COUNT host submission channels into one show-ahead FIFO through a
// round-robin write arbiter, presents the FIFO head to the issuer, tracks
// tasks that were popped but have not finished yet, and reports idle and
// underflow status.
// Ports:
//   i_clk, i_rstn    clock and asynchronous active-low reset
//   qif (slave)      submission handshake (i_push/i_cmd/o_grant) and issuer
//                    handshake (o_cmd/o_empty/i_rd)
//   i_finished_task  one-cycle pulse per completed task
//   i_flush          synchronous FIFO clear
//   o_count          FIFO occupancy
//   o_outstanding    tasks popped but not yet finished
//   o_idle           FIFO empty and nothing outstanding
//   o_err_underflow  sticky: a finish arrived with nothing outstanding
// -----------------------------------------------------------------------------
module cmd_queue_frontend #(
  parameter int CMD_W    = 64,
  parameter int DEPTH    = 16,
  parameter int CH_COUNT = 2,
  parameter int OUT_W    = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  cmd_queue_frontend_if.slave        qif,
  input  logic                       i_finished_task,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [OUT_W-1:0]           o_outstanding,
  output logic                       o_idle,
  output logic                       o_err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int RR_W  = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [OUT_W-1:0] OUT_MAX  = '1;

  logic [CMD_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [RR_W-1:0]     rr_ptr;

  logic                empty;
  logic                full;
  logic                pop;
  logic                wr_allowed;
  logic [CH_COUNT-1:0] grant;
  logic                grant_any;
  logic [RR_W-1:0]     grant_idx;
  logic [RR_W-1:0]     cand;

  // (base + off) mod CH_COUNT, with off < CH_COUNT so one subtraction suffices
  function automatic logic [RR_W-1:0] wrap_idx(input logic [RR_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= CH_COUNT) s = s - CH_COUNT;
    return RR_W'(s);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign pop   = qif.i_rd & ~empty & ~i_flush;

  // A full FIFO still accepts a write when the same cycle frees a slot.
  // Gating with i_rstn keeps o_grant low while reset is asserted.
  assign wr_allowed = i_rstn & ~i_flush & (~full | pop);

  // Round-robin pick: scan offsets from the highest down so the requester
  // closest to rr_ptr (in cyclic order) is the one left standing.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (wr_allowed) begin
      for (int k = CH_COUNT - 1; k >= 0; k--) begin
        cand = wrap_idx(rr_ptr, k);
        if (qif.i_push[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  assign qif.o_grant = grant;
  assign qif.o_cmd   = mem[rd_ptr];
  assign qif.o_empty = empty;
  assign o_count     = count;
  assign o_idle      = empty & (o_outstanding == '0);

  // FIFO storage, pointers, occupancy and arbiter pointer. Flush rewinds
  // both pointers to zero; storage contents are left as they are since the
  // empty flag already hides them.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_any) begin
        mem[wr_ptr] <= qif.i_cmd[grant_idx];
        wr_ptr      <= wr_ptr + PTR_W'(1);
        rr_ptr      <= wrap_idx(grant_idx, 1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({grant_any, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Outstanding-task tracking. A pop and a finish in the same cycle cancel,
  // so that case never flags underflow. The error flag only clears on reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_outstanding   <= '0;
      o_err_underflow <= 1'b0;
    end else begin
      case ({pop, i_finished_task})
        2'b10: begin
          if (o_outstanding != OUT_MAX) o_outstanding <= o_outstanding + OUT_W'(1);
        end
        2'b01: begin
          if (o_outstanding == '0) o_err_underflow <= 1'b1;
          else                     o_outstanding   <= o_outstanding - OUT_W'(1);
        end
        default: o_outstanding <= o_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_queue_frontend.sv
// -----------------------------------------------------------------------------
// tb_cmd_queue_frontend
// Directed bench for cmd_queue_frontend with default parameters
// (CMD_W=64, DEPTH=16, CH_COUNT=2, OUT_W=8). Inputs change 1 time unit after
// the rising edge; outputs are sampled between edges.
// -----------------------------------------------------------------------------
module tb_cmd_queue_frontend;

  localparam int CMD_W    = 64;
  localparam int DEPTH    = 16;
  localparam int CH_COUNT = 2;
  localparam int OUT_W    = 8;

  logic       clk;
  logic       rstn;
  logic       finished_task;
  logic       flush;
  logic [4:0] count;
  logic [7:0] outstanding;
  logic       idle;
  logic       err_underflow;

  int compared;
  int mismatched;

  cmd_queue_frontend_if #(.CMD_W(CMD_W), .CH_COUNT(CH_COUNT)) qif ();

  cmd_queue_frontend #(
    .CMD_W(CMD_W), .DEPTH(DEPTH), .CH_COUNT(CH_COUNT), .OUT_W(OUT_W)
  ) dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .qif             (qif),
    .i_finished_task (finished_task),
    .i_flush         (flush),
    .o_count         (count),
    .o_outstanding   (outstanding),
    .o_idle          (idle),
    .o_err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive every input, then let combinational outputs settle.
  task automatic apply_stimulus(input logic [1:0] push, input logic [63:0] c0,
                                input logic [63:0] c1, input logic rd,
                                input logic fl, input logic fin);
    qif.i_push    = push;
    qif.i_cmd[0]  = c0;
    qif.i_cmd[1]  = c1;
    qif.i_rd      = rd;
    flush         = fl;
    finished_task = fin;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rstn       = 1'b0;
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Reset state
    check_output("rst_empty", qif.o_empty, 1);
    check_output("rst_count", count, 0);
    check_output("rst_grant", qif.o_grant, 0);
    check_output("rst_idle", idle, 1);
    check_output("rst_err", err_underflow, 0);
    check_output("rst_outst", outstanding, 0);
    check_output("rst_cmd", qif.o_cmd, 0);
    #10;
    rstn = 1'b1;
    tick();

    // Single channel back-to-back pushes, then three pops
    apply_stimulus(2'b01, 64'hA1, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("s_grant0", qif.o_grant, 2'b01);
    tick();
    check_output("s_head_a1", qif.o_cmd, 64'hA1);
    check_output("s_nempty", qif.o_empty, 0);
    apply_stimulus(2'b01, 64'hA2, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("s_grant1", qif.o_grant, 2'b01);
    tick();
    apply_stimulus(2'b01, 64'hA3, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("s_count3", count, 3);
    check_output("s_head", qif.o_cmd, 64'hA1);
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("s_pop_a2", qif.o_cmd, 64'hA2);
    tick();
    check_output("s_pop_a3", qif.o_cmd, 64'hA3);
    tick();
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("s_empty", qif.o_empty, 1);
    check_output("s_outst3", outstanding, 3);
    check_output("s_nidle", idle, 0);
    tick();
    check_output("s_hold_outst", outstanding, 3);

    // Two channels pushing continuously alternate, starting from ch0
    pulse_reset();
    apply_stimulus(2'b11, 64'h10, 64'h20, 1'b0, 1'b0, 1'b0);
    check_output("rr_g0", qif.o_grant, 2'b01);
    tick();
    apply_stimulus(2'b11, 64'h11, 64'h20, 1'b0, 1'b0, 1'b0);
    check_output("rr_g1", qif.o_grant, 2'b10);
    tick();
    apply_stimulus(2'b11, 64'h11, 64'h21, 1'b0, 1'b0, 1'b0);
    check_output("rr_g2", qif.o_grant, 2'b01);
    tick();
    apply_stimulus(2'b11, 64'h12, 64'h21, 1'b0, 1'b0, 1'b0);
    check_output("rr_g3", qif.o_grant, 2'b10);
    tick();
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    check_output("rr_count4", count, 4);
    check_output("rr_q0", qif.o_cmd, 64'h10);
    tick();
    check_output("rr_q1", qif.o_cmd, 64'h20);
    tick();
    check_output("rr_q2", qif.o_cmd, 64'h11);
    tick();
    check_output("rr_q3", qif.o_cmd, 64'h21);
    tick();
    check_output("rr_empty", qif.o_empty, 1);

    // Fill to DEPTH, then push while popping at full across the wrap
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(2'b01, 64'h100 + 64'(i), 64'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(2'b01, 64'h110, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("full_count", count, 16);
    check_output("full_grant", qif.o_grant, 2'b00);
    tick();
    check_output("full_hold", count, 16);
    for (int j = 0; j < 20; j++) begin
      apply_stimulus(2'b01, 64'h110 + 64'(j), 64'h0, 1'b1, 1'b0, 1'b0);
      check_output("wrap_grant", qif.o_grant, 2'b01);
      check_output("wrap_count", count, 16);
      check_output("wrap_head", qif.o_cmd, 64'h100 + 64'(j));
      tick();
    end
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      check_output("drain_head", qif.o_cmd, 64'h114 + 64'(k));
      tick();
    end
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("drain_empty", qif.o_empty, 1);
    check_output("drain_outst", outstanding, 36);

    // Flush with simultaneous push and pop
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(2'b01, 64'h50 + 64'(i), 64'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    apply_stimulus(2'b01, 64'h99, 64'h0, 1'b1, 1'b1, 1'b0);
    check_output("fl_pre_count", count, 3);
    check_output("fl_pre_head", qif.o_cmd, 64'h52);
    check_output("fl_grant", qif.o_grant, 2'b00);
    tick();
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("fl_count", count, 0);
    check_output("fl_empty", qif.o_empty, 1);
    check_output("fl_outst", outstanding, 2);
    check_output("fl_idle", idle, 0);

    // Outstanding counter and sticky underflow
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("os_one", outstanding, 1);
    apply_stimulus(2'b01, 64'h60, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("os_popfin", outstanding, 1);
    check_output("os_popfin_empty", qif.o_empty, 1);
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("os_zero", outstanding, 0);
    check_output("os_noerr", err_underflow, 0);
    tick();
    check_output("uf_outst", outstanding, 0);
    check_output("uf_err", err_underflow, 1);
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("uf_sticky", err_underflow, 1);
    check_output("uf_idle", idle, 1);

    // Asynchronous reset in the middle of traffic
    apply_stimulus(2'b01, 64'h70, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(2'b01, 64'h71, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    apply_stimulus(2'b01, 64'h72, 64'h0, 1'b0, 1'b0, 1'b0);
    check_output("mid_count", count, 1);
    check_output("mid_head", qif.o_cmd, 64'h71);
    check_output("mid_outst", outstanding, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_output("ar_count", count, 0);
    check_output("ar_empty", qif.o_empty, 1);
    check_output("ar_cmd", qif.o_cmd, 0);
    check_output("ar_outst", outstanding, 0);
    check_output("ar_err", err_underflow, 0);
    check_output("ar_idle", idle, 1);
    check_output("ar_grant", qif.o_grant, 0);
    apply_stimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    tick();
    check_output("post_empty", qif.o_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
